// File: rtl/retimer_pkg.sv
// Shared types and constants for the retimer polarity calibration block.
// Polarity encodings match the retimer select input.
package retimer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE_A,
    S_MEAS_A,
    S_SETTLE_B,
    S_MEAS_B,
    S_DECIDE
  } cal_state_t;

  localparam logic POL_DIRECT = 1'b0;
  localparam logic POL_NEG    = 1'b1;

  localparam int SETTLE_DEF = 4;

endpackage

// File: rtl/err_window_cnt.sv
// Event counter with terminal count plus saturating error counter.
// Shared by every settle/measure window of the calibration FSM.
module err_window_cnt #(
  parameter int CNT_W = 10,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             evt,
  input  logic             err,
  input  logic             err_en,
  input  logic [CNT_W-1:0] target,
  output logic [ERR_W-1:0] err_cnt,
  output logic [ERR_W-1:0] err_nxt,
  output logic             tc
);

  logic [CNT_W-1:0] evt_cnt;
  logic [CNT_W-1:0] evt_inc;

  always_comb begin
    evt_inc = evt_cnt + 1'b1;
    tc      = evt && (evt_inc == target);
    err_nxt = err_cnt;
    if (evt && err_en && err && (err_cnt != '1))
      err_nxt = err_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      evt_cnt <= '0;
      err_cnt <= '0;
    end else if (evt) begin
      evt_cnt <= evt_inc;
      err_cnt <= err_nxt;
    end
  end

endmodule

// File: rtl/retimer_pol_cal.sv
// Retimer polarity calibration: measures errors on both polarities,
// commits the better one, and supports a manual force override.
import retimer_pkg::*;

module retimer_pol_cal #(
  parameter int CNT_W  = 10,
  parameter int ERR_W  = 8,
  parameter int SETTLE = SETTLE_DEF
) (
  input  logic             CK,
  input  logic             NRST,
  input  logic             EN,
  input  logic             CAL_START,
  input  logic [CNT_W-1:0] WIN_LEN,
  input  logic             EVT,
  input  logic             ERR,
  input  logic             FORCE_EN,
  input  logic             FORCE_POL,
  output logic             POLARITY,
  output logic             CAL_BUSY,
  output logic             CAL_DONE,
  output logic [ERR_W-1:0] ERR_A,
  output logic [ERR_W-1:0] ERR_B
);

  cal_state_t state_q, state_d;

  logic             pol_q;
  logic             pol_cal_q;
  logic             done_q;
  logic [ERR_W-1:0] err_a_q;
  logic [ERR_W-1:0] err_b_q;

  logic             start;
  logic             abort;
  logic             in_settle;
  logic             in_meas;
  logic             clr;
  logic             tc;
  logic             fb_pol;
  logic [CNT_W-1:0] win;
  logic [CNT_W-1:0] target;
  logic [ERR_W-1:0] err_cnt;
  logic [ERR_W-1:0] err_nxt;

  always_comb begin
    start = (state_q == S_IDLE) && CAL_START
          && EN && !FORCE_EN;
    abort = (state_q != S_IDLE) && (!EN || FORCE_EN);
    in_settle = (state_q == S_SETTLE_A)
             || (state_q == S_SETTLE_B);
    in_meas = (state_q == S_MEAS_A)
           || (state_q == S_MEAS_B);
    win    = (WIN_LEN == '0) ? CNT_W'(1) : WIN_LEN;
    target = in_settle ? CNT_W'(SETTLE) : win;
    fb_pol = FORCE_EN ? FORCE_POL : pol_cal_q;

    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:     if (start) state_d = S_SETTLE_A;
        S_SETTLE_A: if (tc) state_d = S_MEAS_A;
        S_MEAS_A:   if (tc) state_d = S_SETTLE_B;
        S_SETTLE_B: if (tc) state_d = S_MEAS_B;
        S_MEAS_B:   if (tc) state_d = S_DECIDE;
        S_DECIDE:   state_d = S_IDLE;
        default:    state_d = S_IDLE;
      endcase
    end
    clr = (state_d != state_q);
  end

  err_window_cnt #(
    .CNT_W(CNT_W),
    .ERR_W(ERR_W)
  ) u_win (
    .clk    (CK),
    .rst_n  (NRST),
    .clr    (clr),
    .evt    (EVT && (in_settle || in_meas)),
    .err    (ERR),
    .err_en (in_meas),
    .target (target),
    .err_cnt(err_cnt),
    .err_nxt(err_nxt),
    .tc     (tc)
  );

  always_ff @(posedge CK) begin
    if (!NRST) begin
      state_q   <= S_IDLE;
      pol_q     <= POL_DIRECT;
      pol_cal_q <= POL_DIRECT;
      done_q    <= 1'b0;
      err_a_q   <= '0;
      err_b_q   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;
      if (start) begin
        pol_q   <= POL_DIRECT;
        err_a_q <= '0;
        err_b_q <= '0;
      end else if (abort) begin
        // partial window counts stay visible after an abort
        pol_q <= fb_pol;
        if (state_q == S_MEAS_A) err_a_q <= err_cnt;
        if (state_q == S_MEAS_B) err_b_q <= err_cnt;
      end else begin
        case (state_q)
          S_IDLE: pol_q <= fb_pol;
          S_MEAS_A: if (tc) begin
            pol_q   <= POL_NEG;
            err_a_q <= err_nxt;
          end
          S_MEAS_B: if (tc) err_b_q <= err_nxt;
          S_DECIDE: begin
            // a tie keeps the direct path for lower latency
            pol_cal_q <= (err_b_q < err_a_q);
            pol_q     <= (err_b_q < err_a_q);
            done_q    <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign POLARITY = pol_q;
  assign CAL_BUSY = (state_q != S_IDLE);
  assign CAL_DONE = done_q;
  assign ERR_A = (state_q == S_MEAS_A) ? err_cnt : err_a_q;
  assign ERR_B = (state_q == S_MEAS_B) ? err_cnt : err_b_q;

endmodule
